// File: rtl/clk_divider_prog.sv
// rtl/clk_divider_prog.sv - multi-channel programmable clock divider with global phase sync
module clk_divider_prog #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] div_ratio,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] ratio;
        logic [CNT_W-1:0] n_raw;
        logic [CNT_W-1:0] n_clamped;
        logic [CNT_W-1:0] high_len;
        logic [CNT_W-1:0] cnt_inc;
        logic             wrap;

        assign n_raw     = div_ratio[i*CNT_W +: CNT_W];
        // Ratios 0 and 1 cannot form a clock, so they behave as divide-by-2.
        assign n_clamped = (n_raw[CNT_W-1:1] == '0) ? CNT_W'(2) : n_raw;
        // ceil(R/2) written so it cannot overflow at R = 2^CNT_W-1.
        assign high_len  = (ratio >> 1) + {{(CNT_W-1){1'b0}}, ratio[0]};
        assign cnt_inc   = cnt + 1'b1;
        assign wrap      = sync || (cnt == ratio - 1'b1);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt        <= CNT_W'(1);
                ratio      <= CNT_W'(2);
                clk_out[i] <= 1'b0;
                tick[i]    <= 1'b0;
            end else if (!en[i]) begin
                // Parking at R-1 makes the first enabled edge a wrap.
                cnt        <= n_clamped - 1'b1;
                ratio      <= n_clamped;
                clk_out[i] <= 1'b0;
                tick[i]    <= 1'b0;
            end else if (wrap) begin
                cnt        <= '0;
                ratio      <= n_clamped;
                clk_out[i] <= 1'b1;
                tick[i]    <= 1'b1;
            end else begin
                cnt        <= cnt_inc;
                clk_out[i] <= (cnt_inc < high_len);
                tick[i]    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_divider_prog.sv
// tb/tb_clk_divider_prog.sv - directed and randomized checks of clk_divider_prog against a period-level model
module tb_clk_divider_prog;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*CNT_W-1:0] div_ratio;
    logic                    sync;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;

    int checks = 0;
    int errors = 0;

    // Model: each channel is idle or at position k inside a period of length p.
    int                mk    [NUM_CH];
    int                mp    [NUM_CH];
    bit                midle [NUM_CH];
    logic [NUM_CH-1:0] exp_out;
    logic [NUM_CH-1:0] exp_tick;

    always #5 clk = ~clk;

    clk_divider_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_ratio (div_ratio),
        .sync      (sync),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    function automatic int clampf(int n);
        return (n < 2) ? 2 : n;
    endfunction

    function automatic int ratio_of(int ch);
        return int'(div_ratio[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic model_outputs();
        for (int i = 0; i < NUM_CH; i++) begin
            exp_out[i]  = !midle[i] && (mk[i] < (mp[i] + 1) / 2);
            exp_tick[i] = !midle[i] && (mk[i] == 0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            midle[i] = 1'b1;
            mk[i]    = 0;
            mp[i]    = 2;
        end
        model_outputs();
    endtask

    task automatic model_edge();
        for (int i = 0; i < NUM_CH; i++) begin
            if (!en[i]) begin
                midle[i] = 1'b1;
            end else if (midle[i] || sync || mk[i] == mp[i] - 1) begin
                mp[i]    = clampf(ratio_of(i));
                mk[i]    = 0;
                midle[i] = 1'b0;
            end else begin
                mk[i]++;
            end
        end
        model_outputs();
    endtask

    task automatic check_vec(string tag, logic [NUM_CH-1:0] got, logic [NUM_CH-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, got, exp);
        end
    endtask

    task automatic check_int(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_vec({tag, "_clk_out"}, clk_out, exp_out);
        check_vec({tag, "_tick"}, tick, exp_tick);
    endtask

    task automatic async_reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_vec("async_rst_clk_out", clk_out, '0);
        check_vec("async_rst_tick", tick, '0);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [CNT_W-1:0] rand_ratio();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 3) return CNT_W'($urandom_range(0, 3));
        if (sel == 9) return CNT_W'(255);
        return CNT_W'($urandom_range(4, 20));
    endfunction

    initial begin
        int highs;
        rst       = 1'b0;
        en        = '0;
        div_ratio = '0;
        sync      = 1'b0;
        model_reset();
        #12;
        check_vec("reset_clk_out", clk_out, '0);
        check_vec("reset_tick", tick, '0);

        // Ratio 4 on channel 0 straight out of reset.
        en = 4'b0001;
        div_ratio[0 +: CNT_W] = 8'd4;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cycle("r4");
            check_vec("r4_pattern", {3'b0, clk_out[0]}, {3'b0, 1'((c % 4) < 2)});
        end

        // Odd and clamped ratios on channels 1..3.
        div_ratio[1*CNT_W +: CNT_W] = 8'd5;
        div_ratio[2*CNT_W +: CNT_W] = 8'd0;
        div_ratio[3*CNT_W +: CNT_W] = 8'd1;
        en = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            cycle("odd_clamp");
            check_vec("n5_pattern", {3'b0, clk_out[1]}, {3'b0, 1'((c % 5) < 3)});
            check_vec("n0_n1_pattern", {2'b0, clk_out[3:2]}, {2'b0, {2{1'((c % 2) == 0)}}});
        end

        // Ratio change 4 -> 6 while cnt=1: current period finishes first.
        en = '0;
        cycle("dis");
        div_ratio[0 +: CNT_W] = 8'd4;
        en = 4'b0001;
        for (int c = 0; c < 16; c++) begin
            if (c == 2) div_ratio[0 +: CNT_W] = 8'd6;
            cycle("ratio_chg");
            check_vec("ratio_chg_pattern", {3'b0, clk_out[0]},
                      {3'b0, (c < 4) ? 1'(c < 2) : 1'(((c - 4) % 6) < 3)});
        end

        // Maximum ratio: 128 high then 127 low.
        en = '0;
        cycle("dis");
        div_ratio[0 +: CNT_W] = 8'd255;
        en = 4'b0001;
        highs = 0;
        for (int c = 0; c < 255; c++) begin
            cycle("n255");
            if (clk_out[0]) highs++;
        end
        check_int("n255_high_count", highs, 128);
        cycle("n255_wrap");
        check_vec("n255_second_tick", {3'b0, tick[0]}, 4'b0001);

        // Out-of-phase channels aligned by a single sync pulse.
        en = '0;
        cycle("dis");
        div_ratio[0 +: CNT_W] = 8'd3;
        div_ratio[1*CNT_W +: CNT_W] = 8'd4;
        en = 4'b0001;
        cycle("sync_pre");
        en = 4'b0011;
        for (int c = 0; c < 4; c++) cycle("sync_pre");
        sync = 1'b1;
        cycle("sync");
        check_vec("sync_both_tick", {2'b0, tick[1:0]}, 4'b0011);
        check_vec("sync_both_rise", {2'b0, clk_out[1:0]}, 4'b0011);
        sync = 1'b0;
        for (int c = 0; c < 12; c++) cycle("sync_post");

        // Channel 2 dropped mid-high phase, then re-enabled.
        div_ratio[2*CNT_W +: CNT_W] = 8'd6;
        en = 4'b1111;
        for (int c = 0; c < 7; c++) cycle("ch2_run");
        en[2] = 1'b0;
        cycle("ch2_drop");
        check_vec("ch2_drop_out", {3'b0, clk_out[2]}, 4'b0000);
        check_vec("ch2_drop_tick", {3'b0, tick[2]}, 4'b0000);
        for (int c = 0; c < 3; c++) cycle("ch2_off");
        en[2] = 1'b1;
        cycle("ch2_reen");
        check_vec("ch2_reen_out_tick", {2'b0, clk_out[2], tick[2]}, 4'b0011);
        for (int c = 0; c < 6; c++) cycle("ch2_after");

        // Asynchronous reset between edges, then recovery.
        async_reset_pulse();
        cycle("rst_recover");
        check_vec("rst_recover_tick", tick, 4'b1111);
        for (int c = 0; c < 6; c++) cycle("rst_after");

        // Randomized operation against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0)
                div_ratio[$urandom_range(0, NUM_CH - 1)*CNT_W +: CNT_W] = rand_ratio();
            sync = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 399) == 0) async_reset_pulse();
            cycle("rand");
        end
        sync = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_divider_prog.md
CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels (>=1).
REQ-002 Parameter CNT_W, default 8: width of each channel's divide ratio and counter (>=2).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 en  input  NUM_CH  per-channel run enable; bit i controls channel i.
REQ-006 div_ratio  input  NUM_CH*CNT_W  per-channel divide ratio N; channel i uses bits [i*CNT_W +: CNT_W].
REQ-007 sync  input  1  global phase-restart strobe for all enabled channels.
REQ-008 clk_out  output  NUM_CH  per-channel divided clock, registered.
REQ-009 tick  output  NUM_CH  per-channel one-cycle pulse marking each clk_out rising edge, registered.

Function
REQ-010 Each channel SHALL hold a counter cnt (CNT_W bits) and a shadow ratio R (CNT_W bits); channels are fully independent except for sync.
REQ-011 Effective ratio SHALL be clamp(N) = 2 when N is 0 or 1, else N; maximum ratio is 2^CNT_W-1.
REQ-012 High-phase length SHALL be H = ceil(R/2); the output period is R cycles: H cycles high, then R-H cycles low.
REQ-013 Disabled channel (en[i]=0) at each edge: cnt <= clamp(N)-1, R <= clamp(N), clk_out[i] <= 0, tick[i] <= 0.
REQ-014 Enabled channel, wrap case (cnt == R-1): cnt <= 0, R <= clamp(N) sampled this edge, clk_out[i] <= 1, tick[i] <= 1.
REQ-015 Enabled channel, otherwise: cnt <= cnt+1, clk_out[i] <= (cnt+1 < H), tick[i] <= 0.
REQ-016 The first edge with en[i]=1 after a disabled period SHALL produce clk_out[i] rising and tick[i]=1, with zero latency beyond the register.
REQ-017 A div_ratio change SHALL take effect only at the next wrap; the period in progress completes with the old R and H.
REQ-018 sync=1 at an edge SHALL force every enabled channel into the wrap case regardless of cnt, with R reloaded from clamp(N).
REQ-019 Priority per channel SHALL be en=0, then sync, then normal counting.
REQ-020 sync SHALL have no effect on disabled channels.
REQ-021 tick[i] SHALL be high for exactly one cycle per period and coincide with the first high cycle of clk_out[i].
REQ-022 clk_out SHALL be glitch-free: it changes only on posedge clk, from a flop, with no combinational output path.
REQ-023 No clk_out bit SHALL drive the clock pin of any internal flop; the block is fully synchronous to clk.

Reset
REQ-024 While rst=0 (asynchronously, regardless of clk): clk_out=0, tick=0, every cnt=1, every R=2.
REQ-025 After rst deasserts with en[i]=1, the first edge SHALL wrap channel i per REQ-014, loading R from div_ratio.
REQ-026 Reset asserted mid-period SHALL abort the period immediately; there is no partial-period completion.

Verification
REQ-027 Ratio 4, en=1 after reset -> clk_out 1,1,0,0 repeating; tick high on cycles 0,4,8,...; first rise on the first enabled edge.
REQ-028 Odd and clamp ratios -> N=5 gives 1,1,1,0,0; N=0 and N=1 each give 1,0 repeating; N=255 (CNT_W=8) gives 128 high, then 127 low.
REQ-029 N changed from 4 to 6 while cnt=1 -> the current period finishes as 1,1,0,0, then 1,1,1,0,0,0 repeats.
REQ-030 Channel 0 at N=3 and channel 1 at N=4 free-running out of phase, one-cycle sync -> both tick and rise on the same edge, then continue at their own ratios.
REQ-031 en[2] dropped mid-high phase -> clk_out[2]=0 and tick[2]=0 on the next edge; re-enable -> rise and tick on the first enabled edge; other channels are undisturbed.
REQ-032 rst pulsed low between edges mid-operation -> all outputs 0 without a clk edge; recovery per REQ-025.
